mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single on-chip RAM port between two requesters in the multicycle RISC-V core.
- Requester one is the instruction fetch (read-only, 32-bit word).
- Requester two is the data path load/store (64-bit read/write).
- Sits between the processing datapath and the RAM: one grant at a time, a fixed-latency read pipeline, and starvation protection for fetch.

Parameters:
- ADDR_W, 64, byte address width of both requester ports and mem_addr.
- MEM_LAT, 1, cycles from the ISSUE cycle until mem_rdata is valid (registered RAM = 1); legal range 1..7.
- STARVE_MAX, 4, consecutive fetch losses after which fetch is forced to win the next arbitration.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held until i_done.
- i_addr  in  ADDR_W  fetch byte address; bit 2 selects the 32-bit half.
- i_rdata  out  32  fetched instruction; valid while i_done=1.
- i_done  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  64  store data, pre-merged by the store splicer.
- d_rdata  out  64  load doubleword; valid while d_done=1.
- d_done  out  1  one-cycle completion pulse for data.
- mem_addr  out  ADDR_W  RAM address, doubleword aligned (low 3 bits forced to 0).
- mem_wdata  out  64  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  64  RAM read data.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: state=IDLE, all outputs 0, starve counter 0.
- Reset mid-operation: mem_we drops immediately (asynchronously), so an in-flight store may be lost. No done pulse is issued for the aborted request.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If neither request is active, stay in IDLE.
  - Otherwise pick a winner, latch its type, address, wdata and we, and go to ISSUE.
  - Requester inputs are sampled only at this edge; later changes are ignored until done.
- Arbitration:
  - d_req alone wins; i_req alone wins.
  - If both are active, data wins unless starve==STARVE_MAX, in which case fetch wins.
  - starve increments (saturating) each time fetch loses while requesting, and clears when fetch is granted.
- ISSUE (1 cycle):
  - mem_addr = latched address with [2:0]=0.
  - mem_we=1 only for a store; mem_wdata = latched data.
  - Store goes to RESP; load goes to WAIT with the wait counter set to MEM_LAT-1.
- WAIT:
  - Decrement each cycle.
  - At the cycle where the counter is 0, register mem_rdata and go to RESP.
- RESP (1 cycle):
  - Assert the winner's done.
  - Fetch: i_rdata = stored[63:32] if latched addr[2]=1, else stored[31:0].
  - Load: d_rdata = stored 64 bits.
  - Next state is IDLE.
- Latency, with the grant edge at T0:
  - Store: mem_we high in T1, d_done in T2.
  - Load/fetch: done at T1+MEM_LAT+1 (T3 with MEM_LAT=1).
- mem_addr and mem_wdata hold their last values outside ISSUE; mem_we is 0 outside ISSUE.
- i_rdata and d_rdata hold their last values after done.
- A req still high in the cycle after done is a new request, arbitrated in IDLE.
- The loser's req is simply not acknowledged; it stays pending with no error.
- Never are both done outputs high, and never is done high outside RESP.

Optional Feature:
MEM_ARBITER_STATS_EN:
- When defined, adds three outputs: stat_i_grants [31:0], stat_d_grants [31:0], stat_conflicts [31:0].
- Each counts IDLE grants of that type, or cycles in IDLE with both requests active; counters wrap at 2^32 and reset to 0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, ISSUE, WAIT, RESP};
  - typedef enum arb_grant_t {GNT_INSTR, GNT_DATA};
  - localparam DWORD_MASK for low-3-bit clearing.
- Sub-module mem_arb_pick: combinational priority select plus the saturating starve counter. Inputs: i_req, d_req, arbitrate strobe. Output: grant.

Test Plan:
- Single fetch: mem holds 0xDEADBEEF_00400093 at 0x8; i_addr=0xC -> mem_addr=0x8 in T1, i_done in T3, i_rdata=0xDEADBEEF.
- Store then load: d_we=1, d_addr=0x13, d_wdata=0x1122334455667788 -> mem_we=1 at mem_addr=0x10 in T1, d_done T2. Then a load of 0x10 -> d_rdata=0x1122334455667788 at T3.
- Conflict: i_req and d_req both high from reset release -> data granted first, fetch granted next, one done per transaction, never both.
- Starvation: STARVE_MAX=2, d_req held high continuously with i_req high -> data, data, then fetch granted on the 3rd arbitration; starve returns to 0.
- MEM_LAT=3: fetch of 0x0 -> i_done exactly 5 cycles after the grant edge, with correct rdata.
- Reset asserted during ISSUE of a store -> mem_we falls without waiting for a clock edge, no d_done; after release, a re-issued request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data RAM-port arbiter.
package mem_arb_pkg;

  localparam int unsigned WAIT_W     = 3;
  localparam logic [63:0] DWORD_MASK = ~64'h7;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {GNT_INSTR, GNT_DATA} arb_grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signal bundle; the arbiter uses the slave modport,
// the requesters plus RAM model use the master modport.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_rdata;
  logic              i_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [63:0]       d_wdata;
  logic [63:0]       d_rdata;
  logic              d_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic              mem_we;
  logic [63:0]       mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_done, d_rdata, d_done, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_done, d_rdata, d_done, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Fetch/data priority select with a saturating fetch-starvation counter.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       arb,
  output arb_grant_t grant
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          starved;

  // Data has priority unless fetch has lost STARVE_MAX times in a row.
  always_comb begin
    starved  = (starve_q == SW'(STARVE_MAX));
    grant    = (d_req && !(i_req && starved)) ? GNT_DATA : GNT_INSTR;
    starve_d = starve_q;
    if (arb) begin
      if (grant == GNT_INSTR) begin
        starve_d = '0;
      end else if (i_req && !starved) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single RAM port shared by instruction fetch and data load/store.
// Optional MEM_ARBITER_STATS_EN adds grant/conflict counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [31:0]  stat_i_grants,
  output logic [31:0]  stat_d_grants,
  output logic [31:0]  stat_conflicts
`endif
);

  arb_state_t        state_q;
  arb_grant_t        gnt_q;
  arb_grant_t        grant;
  logic              we_q;
  logic              hi_q;
  logic [WAIT_W-1:0] wait_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [63:0]       mem_wdata_q;
  logic              mem_we_q;
  logic [31:0]       i_rdata_q;
  logic [63:0]       d_rdata_q;
  logic              i_done_q;
  logic              d_done_q;
  logic              arb;

  assign arb = (state_q == IDLE) && (bus.i_req || bus.d_req);

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk   (clk),
    .reset (reset),
    .i_req (bus.i_req),
    .d_req (bus.d_req),
    .arb   (arb),
    .grant (grant)
  );

  // RAM-side outputs are loaded at the grant edge so they are live during ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_INSTR;
      we_q        <= 1'b0;
      hi_q        <= 1'b0;
      wait_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (arb) begin
            gnt_q   <= grant;
            state_q <= ISSUE;
            if (grant == GNT_DATA) begin
              we_q        <= bus.d_we;
              mem_we_q    <= bus.d_we;
              mem_addr_q  <= bus.d_addr & ADDR_W'(DWORD_MASK);
              mem_wdata_q <= bus.d_wdata;
            end else begin
              we_q       <= 1'b0;
              hi_q       <= bus.i_addr[2];
              mem_addr_q <= bus.i_addr & ADDR_W'(DWORD_MASK);
            end
          end
        end
        ISSUE: begin
          if (we_q) begin
            d_done_q <= 1'b1;
            state_q  <= RESP;
          end else begin
            wait_q  <= WAIT_W'(MEM_LAT - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (wait_q == '0) begin
            if (gnt_q == GNT_INSTR) begin
              i_rdata_q <= hi_q ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
              i_done_q  <= 1'b1;
            end else begin
              d_rdata_q <= bus.mem_rdata;
              d_done_q  <= 1'b1;
            end
            state_q <= RESP;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_done    = d_done_q;

`ifdef MEM_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_i_grants  <= '0;
      stat_d_grants  <= '0;
      stat_conflicts <= '0;
    end else begin
      if (arb && grant == GNT_INSTR) stat_i_grants <= stat_i_grants + 32'd1;
      if (arb && grant == GNT_DATA)  stat_d_grants <= stat_d_grants + 32'd1;
      if (state_q == IDLE && bus.i_req && bus.d_req) stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule
